chan_summ_trig: RTL and testbench
=================================

// Module: chan_summ_trig
// PURPOSE
//  Parametrised channel-sum and trigger block for the channel FPGA, in the CLK125 domain.
//  - Sums NCH masked ADC samples through a pipelined adder tree.
//  - Decides whether the local sum is sent on the GTP sum lanes or a comma is sent instead.
//  - Adds the NEXT sums received from the other FPGAs and raises a trigger with dead time,
//    re-arm hysteresis and a prescaled copy.
//  Generalises the fixed 16-channel summ/trigger path to any channel count, width and link count.
// PARAMETERS
//  NCH    16  number of ADC channels summed
//  DW     12  ADC sample width, signed two's complement (pedestal already subtracted)
//  SW     16  sum width, signed; all sums saturate to this range
//  NEXT   3   number of external sums received over GTP
//  DTW    8   dead-time counter width
// PORTS
//  CLK         in   1         global 125 MHz clock; every register is clocked on the rising edge
//  RST         in   1         synchronous, active-high reset
//  DIN         in   NCH*DW    channel samples, channel i = DIN[i*DW +: DW]
//  SUM_MASK    in   NCH       1 = channel excluded from the sum (contributes 0)
//  SUM_THR     in   SW        summ send threshold, signed
//  EXT_SUM     in   NEXT*SW   sums from the other FPGAs, signed
//  EXT_VALID   in   NEXT      1 = corresponding EXT_SUM valid this cycle (0 means a comma was received)
//  TRIG_THR    in   SW        total-sum trigger threshold, signed
//  DEADTIME    in   DTW       cycles blocked after each trigger
//  PRESCALE    in   16        TRIG_PS fires on every (PRESCALE+1)-th TRIG
//  SUM_O       out  SW        local masked sum
//  SUM_SEND    out  1         1 = transmit SUM_O on the sum lanes, 0 = transmit comma
//  TOTAL_O     out  SW        local sum plus the valid external sums
//  TRIG        out  1         single-cycle trigger pulse
//  TRIG_PS     out  1         single-cycle prescaled trigger pulse, coincident with TRIG
//  TRIG_CNT    out  32        count of TRIG pulses, wraps at 2^32
// BEHAVIOUR
//  Sum pipeline
//  - Input register, then a registered adder tree of depth $clog2(NCH).
//  - SUM_O reflects the DIN sample from L = $clog2(NCH)+1 cycles earlier (L = 5 for NCH = 16).
//  - SUM_MASK is sampled in the input-register stage, together with DIN.
//  - Samples are sign-extended to SW+$clog2(NCH) bits, so the tree is exact internally.
//  - The final stage saturates to [-2^(SW-1), 2^(SW-1)-1].
//  - SUM_SEND = (SUM_O > SUM_THR), signed compare, registered together with SUM_O.
//  Total
//  - TOTAL_O = sat(SUM_O + sum over i of (EXT_VALID[i] ? EXT_SUM[i] : 0)), registered.
//  - Latency is L+1 cycles from DIN. EXT_SUM/EXT_VALID are sampled in the same cycle as SUM_O.
//  Trigger FSM (IDLE, DEAD, REARM), evaluated on TOTAL_O
//  - IDLE: if TOTAL_O >= TRIG_THR (signed), TRIG = 1 for exactly one cycle and the dead
//    counter is loaded with DEADTIME.
//    - If DEADTIME = 0, go to REARM; otherwise go to DEAD.
//  - DEAD: the counter decrements each cycle; leave for REARM in the cycle it would reach 0.
//    TRIG is held 0 throughout.
//  - REARM: stay until TOTAL_O < TRIG_THR, then go to IDLE; TRIG is held 0.
//    A new trigger therefore needs a fresh threshold crossing.
//  - The TRIG pulse is registered: it appears L+2 cycles after the causing DIN (7 for NCH = 16).
//  - TRIG_THR, DEADTIME and PRESCALE are used live. A change takes effect on the next compare
//    or load, and never retriggers a state already passed.
//  Prescaler and counter
//  - A 16-bit prescale counter increments on each TRIG.
//  - When it equals PRESCALE, TRIG_PS fires in the same cycle as TRIG and the counter clears.
//  - With PRESCALE = 0, TRIG_PS = TRIG.
//  - TRIG_CNT increments on each TRIG and wraps from 0xFFFFFFFF to 0.
//  Reset
//  - All pipeline registers, SUM_O, TOTAL_O, SUM_SEND, TRIG, TRIG_PS, TRIG_CNT, the prescale
//    counter and the dead counter go to 0. The FSM goes to IDLE.
//  - Reset mid-dead-time or mid-REARM aborts that state.
//  - The earliest TRIG after reset release is L+2 cycles later; the pipeline holds zeros until then.
// TESTING
//  1. All 16 channels = 100, mask 0 -> SUM_O = 1600 after 5 cycles.
//     Mask 0x00FF -> SUM_O = 800; excluded channels contribute 0.
//  2. Saturation: all channels = 2047 with SW = 12 -> SUM_O = 2047.
//     All channels = -2048 -> SUM_O = -2048, with no wrap.
//  3. SUM_THR = 500: SUM_O = 500 -> SUM_SEND = 0; SUM_O = 501 -> SUM_SEND = 1.
//  4. External sums: EXT_SUM = {300, 200, 100}, EXT_VALID = 3'b101, SUM_O = 50 -> TOTAL_O = 450.
//  5. TRIG_THR = 1000, DEADTIME = 10, total held at 1200 for 50 cycles -> exactly one TRIG,
//     7 cycles after DIN steps up.
//     Drop the total to 0, then raise it again -> second TRIG; TRIG_CNT = 2.
//  6. PRESCALE = 3, 8 separate crossings -> TRIG_PS on TRIG #4 and #8 only.
//     RST asserted during DEAD -> all outputs 0, then a normal trigger after release.

Source files
------------

// File: rtl/chan_summ_trig.sv
// -----------------------------------------------------------------------------
// chan_summ_trig
//   Channel-sum and trigger block (CLK125 domain).
//   * Sums NCH masked, signed ADC samples through a registered adder tree and
//     saturates the result to SW bits (SUM_O).
//   * SUM_SEND selects local sum vs. comma on the GTP sum lanes.
//   * Adds the valid external sums (TOTAL_O) and runs the trigger FSM
//     (IDLE -> DEAD -> REARM) with dead time, re-arm hysteresis, a prescaled
//     trigger copy and a free-running trigger counter.
//
// Ports
//   CLK        in   clock, all registers on the rising edge
//   RST        in   synchronous active-high reset
//   DIN        in   NCH*DW  samples, channel i = DIN[i*DW +: DW]
//   SUM_MASK   in   NCH     1 = channel excluded from the sum
//   SUM_THR    in   SW      send threshold (signed)
//   EXT_SUM    in   NEXT*SW external sums (signed)
//   EXT_VALID  in   NEXT    1 = matching EXT_SUM is valid this cycle
//   TRIG_THR   in   SW      trigger threshold (signed)
//   DEADTIME   in   DTW     cycles blocked after each trigger
//   PRESCALE   in   16      TRIG_PS on every (PRESCALE+1)-th TRIG
//   SUM_O      out  SW      local masked sum, latency $clog2(NCH)+1
//   SUM_SEND   out  1       SUM_O > SUM_THR
//   TOTAL_O    out  SW      SUM_O + valid external sums, saturated
//   TRIG       out  1       single-cycle trigger pulse
//   TRIG_PS    out  1       prescaled trigger, coincident with TRIG
//   TRIG_CNT   out  32      number of TRIG pulses (wraps)
//
// NCH must be at least 2.
// -----------------------------------------------------------------------------
module chan_summ_trig #(
  parameter int NCH  = 16,
  parameter int DW   = 12,
  parameter int SW   = 16,
  parameter int NEXT = 3,
  parameter int DTW  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*DW-1:0]    DIN,
  input  logic [NCH-1:0]       SUM_MASK,
  input  logic [SW-1:0]        SUM_THR,
  input  logic [NEXT*SW-1:0]   EXT_SUM,
  input  logic [NEXT-1:0]      EXT_VALID,
  input  logic [SW-1:0]        TRIG_THR,
  input  logic [DTW-1:0]       DEADTIME,
  input  logic [15:0]          PRESCALE,
  output logic [SW-1:0]        SUM_O,
  output logic                 SUM_SEND,
  output logic [SW-1:0]        TOTAL_O,
  output logic                 TRIG,
  output logic                 TRIG_PS,
  output logic [31:0]          TRIG_CNT
);

  localparam int LG = $clog2(NCH);
  localparam int NP = 1 << LG;                     // tree leaves, padded to a power of two
  localparam int XW = SW + LG;                     // exact width inside the tree
  localparam int AW = SW + $clog2(NEXT + 1) + 1;   // exact width of the total
  localparam int WW = (XW > AW) ? XW : AW;         // common width fed to the saturator

  localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEAD  = 2'd1,
    S_REARM = 2'd2
  } state_t;

  // Clamp an exact wide value into the signed SW-bit range.
  function automatic logic signed [SW-1:0] sat_sw(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] hi;
    logic signed [WW-1:0] lo;
    hi = WW'(SMAX);
    lo = WW'(SMIN);
    if (v > hi) begin
      return SMAX;
    end else if (v < lo) begin
      return SMIN;
    end else begin
      return v[SW-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Sum pipeline: level 0 is the input register, levels 1..LG-1 are the tree,
  // the last addition is saturated straight into SUM_O.
  // ---------------------------------------------------------------------------
  logic signed [XW-1:0] in_d   [NP];
  logic signed [XW-1:0] tree_q [LG][NP];
  logic signed [WW-1:0] fin_s;
  logic signed [SW-1:0] sum_d, sum_q;
  logic                 send_d, send_q;

  // Masked, sign-extended leaves; padding leaves are zero.
  always_comb begin
    for (int j = 0; j < NP; j++) begin
      if (j < NCH && !SUM_MASK[j]) begin
        in_d[j] = XW'($signed(DIN[j*DW +: DW]));
      end else begin
        in_d[j] = '0;
      end
    end
  end

  // Input register and intermediate tree levels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int l = 0; l < LG; l++) begin
        for (int j = 0; j < NP; j++) begin
          tree_q[l][j] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < NP; j++) begin
        tree_q[0][j] <= in_d[j];
      end
      for (int l = 1; l < LG; l++) begin
        for (int j = 0; j < (NP >> l); j++) begin
          tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
        end
      end
    end
  end

  // Last tree addition, saturation and send decision share one stage.
  always_comb begin
    fin_s  = WW'(tree_q[LG-1][0]) + WW'(tree_q[LG-1][1]);
    sum_d  = sat_sw(fin_s);
    send_d = (sum_d > $signed(SUM_THR));
  end

  // ---------------------------------------------------------------------------
  // Total: local sum plus valid external sums, one stage after SUM_O.
  // ---------------------------------------------------------------------------
  logic signed [WW-1:0] acc_s;
  logic signed [SW-1:0] total_d, total_q;

  // External sums flagged invalid (comma received) contribute nothing.
  always_comb begin
    acc_s = WW'(sum_q);
    for (int i = 0; i < NEXT; i++) begin
      if (EXT_VALID[i]) begin
        acc_s = acc_s + WW'($signed(EXT_SUM[i*SW +: SW]));
      end else begin
        acc_s = acc_s;
      end
    end
    total_d = sat_sw(acc_s);
  end

  // ---------------------------------------------------------------------------
  // Trigger FSM, prescaler and counter.
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [DTW-1:0] dead_q, dead_d;
  logic           trig_d, trig_q;
  logic           trig_ps_d, trig_ps_q;
  logic [15:0]    ps_cnt_d, ps_cnt_q;
  logic [31:0]    trig_cnt_d, trig_cnt_q;

  // Next state: fire once per crossing, block for DEADTIME cycles, then wait
  // for the total to fall below threshold before re-arming.
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    trig_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (total_q >= $signed(TRIG_THR)) begin
          trig_d  = 1'b1;
          dead_d  = DEADTIME;
          state_d = (DEADTIME == '0) ? S_REARM : S_DEAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DEAD: begin
        // Leave on the decrement that reaches zero; <= also recovers from 0.
        if (dead_q <= DTW'(1)) begin
          dead_d  = '0;
          state_d = S_REARM;
        end else begin
          dead_d  = dead_q - DTW'(1);
          state_d = S_DEAD;
        end
      end
      S_REARM: begin
        if (total_q < $signed(TRIG_THR)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REARM;
        end
      end
      default: begin
        state_d = S_IDLE;
        dead_d  = '0;
      end
    endcase
  end

  // Prescaler and counter advance on the trigger decision so TRIG_PS and
  // TRIG_CNT register together with TRIG. The >= test lets a PRESCALE that
  // is lowered below the running count fire on the next trigger instead of
  // waiting for a 16-bit wrap.
  always_comb begin
    trig_ps_d  = 1'b0;
    ps_cnt_d   = ps_cnt_q;
    trig_cnt_d = trig_cnt_q;
    if (trig_d) begin
      trig_cnt_d = trig_cnt_q + 32'd1;
      if (ps_cnt_q >= PRESCALE) begin
        trig_ps_d = 1'b1;
        ps_cnt_d  = 16'd0;
      end else begin
        ps_cnt_d  = ps_cnt_q + 16'd1;
      end
    end else begin
      trig_ps_d = 1'b0;
    end
  end

  // Output, total and trigger state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_q      <= '0;
      send_q     <= 1'b0;
      total_q    <= '0;
      state_q    <= S_IDLE;
      dead_q     <= '0;
      trig_q     <= 1'b0;
      trig_ps_q  <= 1'b0;
      ps_cnt_q   <= 16'd0;
      trig_cnt_q <= 32'd0;
    end else begin
      sum_q      <= sum_d;
      send_q     <= send_d;
      total_q    <= total_d;
      state_q    <= state_d;
      dead_q     <= dead_d;
      trig_q     <= trig_d;
      trig_ps_q  <= trig_ps_d;
      ps_cnt_q   <= ps_cnt_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign SUM_O    = sum_q;
  assign SUM_SEND = send_q;
  assign TOTAL_O  = total_q;
  assign TRIG     = trig_q;
  assign TRIG_PS  = trig_ps_q;
  assign TRIG_CNT = trig_cnt_q;

endmodule

// File: tb/tb_chan_summ_trig.sv
// -----------------------------------------------------------------------------
// tb_chan_summ_trig
//   Directed bench for chan_summ_trig. One instance uses the default
//   parameters; a second instance with SW = 12 shares DIN/SUM_MASK to exercise
//   saturation. Inputs are driven 1 time unit after a rising edge and outputs
//   are sampled at the same point, so "step(n)" means n rising edges.
// -----------------------------------------------------------------------------
module tb_chan_summ_trig;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic [191:0]  DIN;
  logic [15:0]   SUM_MASK;
  logic [15:0]   SUM_THR;
  logic [47:0]   EXT_SUM;
  logic [2:0]    EXT_VALID;
  logic [15:0]   TRIG_THR;
  logic [7:0]    DEADTIME;
  logic [15:0]   PRESCALE;
  logic [15:0]   SUM_O;
  logic          SUM_SEND;
  logic [15:0]   TOTAL_O;
  logic          TRIG;
  logic          TRIG_PS;
  logic [31:0]   TRIG_CNT;

  // Saturation instance (SW = 12).
  logic [11:0]   s_thr       = 12'd0;
  logic [35:0]   s_ext       = 36'd0;
  logic [2:0]    s_ext_valid = 3'd0;
  logic [11:0]   s_trig_thr  = 12'h7FF;
  logic [11:0]   s_sum;
  logic          s_send;
  logic [11:0]   s_total;
  logic          s_trig;
  logic          s_trig_ps;
  logic [31:0]   s_cnt;

  chan_summ_trig u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .SUM_MASK(SUM_MASK), .SUM_THR(SUM_THR),
    .EXT_SUM(EXT_SUM), .EXT_VALID(EXT_VALID), .TRIG_THR(TRIG_THR),
    .DEADTIME(DEADTIME), .PRESCALE(PRESCALE), .SUM_O(SUM_O), .SUM_SEND(SUM_SEND),
    .TOTAL_O(TOTAL_O), .TRIG(TRIG), .TRIG_PS(TRIG_PS), .TRIG_CNT(TRIG_CNT)
  );

  chan_summ_trig #(.SW(12)) u_dut12 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .SUM_MASK(SUM_MASK), .SUM_THR(s_thr),
    .EXT_SUM(s_ext), .EXT_VALID(s_ext_valid), .TRIG_THR(s_trig_thr),
    .DEADTIME(DEADTIME), .PRESCALE(PRESCALE), .SUM_O(s_sum), .SUM_SEND(s_send),
    .TOTAL_O(s_total), .TRIG(s_trig), .TRIG_PS(s_trig_ps), .TRIG_CNT(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_all(input logic [11:0] v);
    for (int i = 0; i < 16; i++) DIN[i*12 +: 12] = v;
  endtask

  task automatic set_ch0(input logic [11:0] v);
    DIN = '0;
    DIN[11:0] = v;
  endtask

  // Channel 0 = 1200 for one cycle at c = 0 and c = gap, 0 otherwise.
  // Reports number of TRIGs, edge of the first TRIG, and TRIG_PS count.
  task automatic pulses(input int gap, input int ncyc,
                        output int ntrig, output int first, output int nps);
    ntrig = 0; first = -1; nps = 0;
    for (int c = 0; c < ncyc; c++) begin
      set_ch0((c == 0 || c == gap) ? 12'd1200 : 12'd0);
      step(1);
      if (TRIG) begin
        ntrig++;
        if (first < 0) first = c + 1;
      end
      if (TRIG_PS) nps++;
    end
    DIN = '0;
  endtask

  int nt, fe, np;
  logic [7:0] ps_mask;

  initial begin
    RST = 1'b1; DIN = '0; SUM_MASK = 16'h0000; SUM_THR = 16'd500;
    EXT_SUM = '0; EXT_VALID = 3'b000; TRIG_THR = 16'h7FFF;
    DEADTIME = 8'd10; PRESCALE = 16'd0;
    step(3);
    chk("rst_sum", 32'(SUM_O), 32'd0);
    chk("rst_total", 32'(TOTAL_O), 32'd0);
    chk("rst_send_trig", {29'd0, SUM_SEND, TRIG, TRIG_PS}, 32'd0);
    chk("rst_cnt", TRIG_CNT, 32'd0);
    RST = 1'b0;

    // Plain sum, latency 5, then mask.
    set_all(12'd100);
    step(4);
    chk("sum_early", 32'(SUM_O), 32'd0);
    step(1);
    chk("sum_1600", 32'(SUM_O), 32'd1600);
    chk("send_1600", 32'(SUM_SEND), 32'd1);
    SUM_MASK = 16'h00FF;
    step(5);
    chk("sum_mask", 32'(SUM_O), 32'd800);

    // Saturation on the SW = 12 instance; exact on the default instance.
    SUM_MASK = 16'h0000;
    set_all(12'd2047);
    step(5);
    chk("sat_pos", 32'(s_sum), 32'h7FF);
    chk("sat_send", 32'(s_send), 32'd1);
    chk("exact_pos", 32'(SUM_O), 32'h7FF0);
    step(1);
    chk("sat_total", 32'(s_total), 32'h7FF);
    set_all(12'h800);
    step(5);
    chk("sat_neg", 32'(s_sum), 32'h800);
    chk("exact_neg", 32'(SUM_O), 32'h8000);
    chk("sat12_trigcnt", s_cnt, 32'd1);
    chk("sat12_trig_idle", {30'd0, s_trig, s_trig_ps}, 32'd0);

    // Send threshold boundary, and a signed compare.
    set_ch0(12'd500);
    step(5);
    chk("sum_500", 32'(SUM_O), 32'd500);
    chk("send_500", 32'(SUM_SEND), 32'd0);
    set_ch0(12'd501);
    step(5);
    chk("send_501", 32'(SUM_SEND), 32'd1);
    SUM_THR = 16'hFFF6;
    set_ch0(12'hFFB);
    step(5);
    chk("sum_m5", 32'(SUM_O), 32'hFFFB);
    chk("send_neg", 32'(SUM_SEND), 32'd1);
    SUM_THR = 16'd500;

    // External sums.
    set_ch0(12'd50);
    EXT_SUM = {16'd300, 16'd200, 16'd100};
    EXT_VALID = 3'b101;
    step(6);
    chk("total_450", 32'(TOTAL_O), 32'd450);
    EXT_VALID = 3'b010;
    step(1);
    chk("total_250", 32'(TOTAL_O), 32'd250);
    EXT_SUM = {3{16'h8AD0}};
    EXT_VALID = 3'b111;
    step(1);
    chk("total_satneg", 32'(TOTAL_O), 32'h8000);
    EXT_SUM = '0;
    EXT_VALID = 3'b000;

    // Trigger: held crossing gives one TRIG, 7 edges after DIN.
    DIN = '0;
    TRIG_THR = 16'd1000;
    step(10);
    chk("cnt_before", TRIG_CNT, 32'd0);
    nt = 0; fe = -1; np = 0;
    set_ch0(12'd1200);
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (TRIG) begin
        nt++;
        if (fe < 0) fe = c + 1;
      end
      if (TRIG_PS) np++;
    end
    chk("hold_ntrig", nt, 32'd1);
    chk("hold_lat", fe, 32'd7);
    chk("hold_ps", np, 32'd1);
    DIN = '0;
    step(10);
    fe = -1;
    set_ch0(12'd1200);
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (TRIG && fe < 0) fe = c + 1;
    end
    chk("retrig_lat", fe, 32'd7);
    chk("cnt_2", TRIG_CNT, 32'd2);
    DIN = '0;
    step(30);

    // Dead time 10: second pulse 11 cycles later falls in DEAD/REARM, 12 re-fires.
    pulses(11, 50, nt, fe, np);
    chk("dead_gap11", nt, 32'd1);
    pulses(12, 50, nt, fe, np);
    chk("dead_gap12", nt, 32'd2);
    chk("cnt_5", TRIG_CNT, 32'd5);

    // Prescale 3 over 8 separate crossings.
    PRESCALE = 16'd3;
    DEADTIME = 8'd2;
    ps_mask = 8'd0;
    for (int k = 0; k < 8; k++) begin
      pulses(0, 20, nt, fe, np);
      if (np != 0) ps_mask[k] = 1'b1;
    end
    chk("ps_mask", 32'(ps_mask), 32'h88);
    chk("cnt_13", TRIG_CNT, 32'd13);

    // Reset in the middle of a long dead time.
    PRESCALE = 16'd0;
    DEADTIME = 8'd200;
    pulses(0, 10, nt, fe, np);
    chk("pre_rst_trig", nt, 32'd1);
    chk("cnt_14", TRIG_CNT, 32'd14);
    RST = 1'b1;
    step(2);
    chk("mid_rst_cnt", TRIG_CNT, 32'd0);
    chk("mid_rst_out", {SUM_O, TOTAL_O}, 32'd0);
    chk("mid_rst_bits", {29'd0, SUM_SEND, TRIG, TRIG_PS}, 32'd0);
    RST = 1'b0;
    DEADTIME = 8'd10;
    pulses(0, 30, nt, fe, np);
    chk("post_rst_ntrig", nt, 32'd1);
    chk("post_rst_lat", fe, 32'd7);
    chk("post_rst_cnt", TRIG_CNT, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
